// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters,
// with a per-grant burst limit and a watchdog on the transmitter's done tick.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int DBIT      = 8,
   parameter int MAX_BURST = 4,
   parameter int TO_BITS   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DBIT-1:0] req_data,
   output logic [NREQ-1:0]      req_ack,
   output logic [NREQ-1:0]      grant,
   output logic                 tx_start,
   output logic [DBIT-1:0]      tx_din,
   input  logic                 tx_done_tick,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   localparam logic [TO_BITS-1:0] WD_MAX    = '1;
   localparam logic [BC_W-1:0]    BURST_MAX = BC_W'(MAX_BURST);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NREQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NREQ-1:0]    r_grant;
   logic [IDX_W-1:0]   r_last;
   logic [BC_W-1:0]    r_burst;
   logic [TO_BITS-1:0] r_wd;
   logic [DBIT-1:0]    r_tx_din;
   logic               r_timeout;

   logic               w_pick_valid;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [IDX_W-1:0]   w_cand;
   logic [IDX_W-1:0]   w_gidx;
   logic               w_start_grant;
   logic               w_continue;
   logic               w_release;
   logic               w_expire;

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = (32'(base) + k) % NREQ;
      return IDX_W'(s);
   endfunction

   // Walk offsets from farthest to nearest so the requester just after
   // last_grant is the final (winning) assignment.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_cand = rr_idx(r_last, k);
         if (req[w_cand]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant[i]) w_gidx = IDX_W'(i);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_start_grant = 1'b0;
      w_continue    = 1'b0;
      w_release     = 1'b0;
      w_expire      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pick_valid) begin
               w_start_grant = 1'b1;
               w_state_nxt   = S_LOAD;
            end
         end
         S_LOAD: w_state_nxt = S_WAIT;
         S_WAIT: begin
            // A done tick in the same cycle as expiry wins over the watchdog.
            if (tx_done_tick) begin
               if (req[w_gidx] && (r_burst < BURST_MAX)) begin
                  w_continue  = 1'b1;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_release   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else if (r_wd == WD_MAX) begin
               w_release   = 1'b1;
               w_expire    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant   <= '0;
         r_last    <= IDX_LAST;
         r_burst   <= '0;
         r_wd      <= '0;
         r_tx_din  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_start_grant) begin
            r_grant  <= NREQ'(1) << w_pick_idx;
            r_tx_din <= req_data[w_pick_idx*DBIT +: DBIT];
            r_burst  <= BC_W'(1);
         end
         if (w_continue) begin
            r_tx_din <= req_data[w_gidx*DBIT +: DBIT];
            r_burst  <= r_burst + 1'b1;
         end
         if (w_release) begin
            r_last  <= w_gidx;
            r_grant <= '0;
            r_burst <= '0;
         end
         if (r_state == S_LOAD) begin
            r_wd <= '0;
         end else if ((r_state == S_WAIT) && !tx_done_tick && (r_wd != WD_MAX)) begin
            r_wd <= r_wd + 1'b1;
         end
      end
   end

   assign tx_start    = (r_state == S_LOAD);
   assign req_ack     = (r_state == S_LOAD) ? r_grant : '0;
   assign grant       = r_grant;
   assign tx_din      = r_tx_din;
   assign busy        = (r_state != S_IDLE);
   assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT, a
// transmitter model returns done ticks, and every tx_start is checked in order.
module tb_uart_tx_arbiter;

   localparam int NREQ      = 4;
   localparam int DBIT      = 8;
   localparam int MAX_BURST = 4;
   localparam int TO_BITS   = 4;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [NREQ-1:0]      req;
   logic [NREQ*DBIT-1:0] req_data;
   logic [NREQ-1:0]      req_ack;
   logic [NREQ-1:0]      grant;
   logic                 tx_start;
   logic [DBIT-1:0]      tx_din;
   logic                 tx_done_tick;
   logic                 busy;
   logic                 timeout_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST), .TO_BITS(TO_BITS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
      .req_ack(req_ack), .grant(grant), .tx_start(tx_start), .tx_din(tx_din),
      .tx_done_tick(tx_done_tick), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      int             idx;
      logic [DBIT-1:0] data;
   } exp_t;

   exp_t            exp_q[$];
   logic [DBIT-1:0] src_q[NREQ][$];

   int n_total = 0;
   int n_bad   = 0;
   int n_cyc   = 0;
   int n_to    = 0;
   int last_start = -100;
   int tx_cnt  = 0;
   int tx_lat  = 3;
   bit tx_mute = 1'b0;
   bit stale_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, n_cyc);
      end
   endtask

   function automatic bit srcs_empty();
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push_src(input int i, input logic [DBIT-1:0] d);
      src_q[i].push_back(d);
   endtask

   task automatic push_exp(input int i, input logic [DBIT-1:0] d);
      exp_t e;
      e.idx  = i;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic clear_model();
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      exp_q.delete();
      tx_cnt       = 0;
      tx_done_tick = 1'b0;
      req          = '0;
      req_data     = '0;
   endtask

   task automatic monitor();
      exp_t e;
      n_cyc++;
      check("busy_vs_grant", 32'(busy), 32'(|grant));
      if (tx_start) begin
         check("start_gap", 32'((n_cyc - last_start) >= 2), 32'd1);
         last_start = n_cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_start_grant", 32'(grant), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("grant", 32'(grant), 32'(1 << e.idx));
            check("tx_din", 32'(tx_din), 32'(e.data));
            check("req_ack", 32'(req_ack), 32'(1 << e.idx));
         end
      end else begin
         check("ack_without_start", 32'(req_ack), 32'd0);
      end
      if (timeout_err) n_to++;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (req_ack[i] && (src_q[i].size() != 0)) void'(src_q[i].pop_front());
      end
      tx_done_tick = 1'b0;
      if (tx_start) begin
         tx_cnt = tx_lat;
         if (stale_done) tx_done_tick = 1'b1;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
         if ((tx_cnt == 0) && !tx_mute) tx_done_tick = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (src_q[i].size() != 0);
         req_data[i*DBIT +: DBIT] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      drive();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_model();
      repeat (2) cycle();
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      while (n < budget) begin
         cycle();
         n++;
         if ((exp_q.size() == 0) && !busy && srcs_empty()) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_drained"}, 32'(ok), 32'd1);
      repeat (3) cycle();
   endtask

   task automatic wait_start(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!tx_start && (n < budget));
      check({tag, "_start_seen"}, 32'(tx_start), 32'd1);
   endtask

   initial begin
      int n;
      int to_base;

      reset_n = 1'b0;
      clear_model();
      repeat (2) cycle();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_req_ack", 32'(req_ack), 32'd0);
      check("rst_tx_din", 32'(tx_din), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      reset_n = 1'b1;
      cycle();

      // Single request from requester 0.
      push_src(0, 8'h55); push_exp(0, 8'h55);
      run_idle("single", 50);
      check("single_grant_idle", 32'(grant), 32'd0);
      check("single_busy_idle", 32'(busy), 32'd0);
      check("single_din_held", 32'(tx_din), 32'h55);

      // Round robin, with a stale done tick during every LOAD cycle.
      do_reset();
      stale_done = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         push_src(i, 8'hA0 + 8'(i));
         push_exp(i, 8'hA0 + 8'(i));
      end
      run_idle("rr1", 100);
      stale_done = 1'b0;
      push_src(0, 8'hC0); push_src(2, 8'hC2);
      push_exp(0, 8'hC0); push_exp(2, 8'hC2);
      run_idle("rr2", 60);
      push_src(1, 8'hD1); push_src(3, 8'hD3);
      push_exp(3, 8'hD3); push_exp(1, 8'hD1);
      run_idle("rr3", 60);

      // Burst limit; requester 2 arrives mid-burst and waits for release.
      do_reset();
      for (int b = 1; b <= 6; b++) push_src(0, 8'(b));
      push_src(1, 8'h11);
      for (int b = 1; b <= 4; b++) push_exp(0, 8'(b));
      push_exp(1, 8'h11); push_exp(2, 8'h22);
      push_exp(0, 8'h05); push_exp(0, 8'h06);
      n = 0;
      while ((exp_q.size() > 6) && (n < 100)) begin
         cycle();
         n++;
      end
      check("burst_two_started", 32'(exp_q.size()), 32'd6);
      push_src(2, 8'h22);
      run_idle("burst", 300);

      // Requester drops right after its ack: one byte, release on done.
      do_reset();
      push_src(2, 8'h77); push_exp(2, 8'h77);
      wait_start("drop", 20);
      repeat (3) cycle();
      check("drop_busy_wait", 32'(busy), 32'd1);
      check("drop_grant_wait", 32'(grant), 32'h4);
      cycle();
      check("drop_busy_release", 32'(busy), 32'd0);
      check("drop_grant_release", 32'(grant), 32'd0);
      run_idle("drop", 20);

      // Watchdog expiry with no done tick at all.
      do_reset();
      to_base = n_to;
      tx_mute = 1'b1;
      push_src(3, 8'h3C); push_exp(3, 8'h3C);
      wait_start("wd", 20);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!timeout_err && (n < 40));
      check("wd_latency", 32'(n), 32'd17);
      check("wd_grant", 32'(grant), 32'd0);
      check("wd_busy", 32'(busy), 32'd0);
      cycle();
      check("wd_pulse_width", 32'(timeout_err), 32'd0);
      tx_mute = 1'b0;
      run_idle("wd", 20);
      check("wd_count", 32'(n_to - to_base), 32'd1);

      // Done in the very cycle of expiry: done wins.
      tx_lat = 16;
      push_src(1, 8'h1E); push_exp(1, 8'h1E);
      run_idle("wd_tie", 60);
      check("wd_tie_no_err", 32'(n_to - to_base), 32'd1);

      // Done one cycle too late: the watchdog has already fired.
      tx_lat = 17;
      push_src(2, 8'h2E); push_exp(2, 8'h2E);
      run_idle("wd_late", 60);
      check("wd_late_err", 32'(n_to - to_base), 32'd2);
      tx_lat = 3;

      // Reset mid-burst restores last_grant so requester 1 beats requester 2.
      do_reset();
      push_src(1, 8'h61); push_exp(1, 8'h61);
      run_idle("pre_rst", 40);
      tx_lat = 10;
      push_src(3, 8'hB0); push_src(3, 8'hB1); push_exp(3, 8'hB0);
      wait_start("mid_rst", 20);
      repeat (3) cycle();
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_tx_start", 32'(tx_start), 32'd0);
      check("mid_rst_req_ack", 32'(req_ack), 32'd0);
      check("mid_rst_tx_din", 32'(tx_din), 32'd0);
      clear_model();
      repeat (2) cycle();
      reset_n = 1'b1;
      tx_lat  = 3;
      push_src(1, 8'h62); push_src(2, 8'h63);
      push_exp(1, 8'h62); push_exp(2, 8'h63);
      run_idle("post_rst", 60);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit: run did not finish, got=running want=finished");
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single UART transmitter among NREQ byte requesters. It selects one requester, loads its byte into the transmitter and pulses the transmitter's start strobe. It then waits for the transmitter's done tick before granting again. A granted requester may hold the transmitter for a burst of up to MAX_BURST bytes, and a watchdog releases the grant if the transmitter never completes.

## Interface
- NREQ, 4, number of requesters (2..8)
- DBIT, 8, data bits per byte; matches the UART transmitter
- MAX_BURST, 4, maximum consecutive bytes per grant (>=1)
- TO_BITS, 16, watchdog counter width; timeout after 2^TO_BITS-1 cycles in WAIT

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester "byte valid", level; held until ack
- req_data  in  NREQ*DBIT  byte of requester i at [i*DBIT +: DBIT]; stable while req[i] high
- req_ack  out  NREQ  one-cycle pulse: byte of requester i accepted
- grant  out  NREQ  one-hot owner of the transmitter, 0 when idle
- tx_start  out  1  one-cycle start strobe to the UART transmitter
- tx_din  out  DBIT  byte to transmit; valid while tx_start high, held until next load
- tx_done_tick  in  1  transmitter finished the current byte (one-cycle pulse)
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog expires

## Operation
- States: IDLE, LOAD, WAIT. Registers: state, grant, last_grant (index), burst_cnt, wd_cnt, tx_din.
- IDLE, req != 0:
  - Pick the first set req index searching circularly from last_grant+1.
  - Register grant to that index.
  - Latch tx_din from its req_data.
  - Set burst_cnt = 1 and go to LOAD.
- IDLE, req == 0: stay; grant = 0.
- LOAD (always exactly one cycle):
  - tx_start = 1 and req_ack[g] = 1, both decoded from state.
  - wd_cnt = 0; go to WAIT.
  - tx_done_tick here is stale and ignored.
- WAIT: wd_cnt increments each cycle without tx_done_tick.
- WAIT, tx_done_tick, req[g] = 1 and burst_cnt < MAX_BURST:
  - Latch tx_din from req_data[g].
  - burst_cnt += 1; go to LOAD. Grant is unchanged.
- WAIT, tx_done_tick otherwise (release):
  - last_grant = g; grant = 0; burst_cnt = 0; go to IDLE.
- WAIT, wd_cnt == 2^TO_BITS-1 with no tx_done_tick:
  - Pulse timeout_err for one cycle.
  - Release as above; the byte is considered lost.
- tx_done_tick and watchdog expiry in the same cycle: done wins; no timeout_err.
- req[g] dropping during WAIT does not abort the transfer. The accepted byte completes, then the grant is released.
- Requester contract: after req_ack, a requester either drops req or presents its next byte in the following cycle.
- Requests arriving during a burst are served only after release. Round-robin continues from the released index.
- Reset values:
  - State and counters: state = IDLE, grant = 0, last_grant = NREQ-1 (requester 0 wins first), burst_cnt = 0, wd_cnt = 0.
  - Outputs: tx_din = 0, tx_start = 0, req_ack = 0, busy = 0, timeout_err = 0.
- Reset mid-operation returns all registers to their reset values immediately. No ack or start is issued for a byte pending at that moment.

## Timing
- req sampled high in IDLE at edge 0: grant valid after edge 0; tx_start and req_ack high for the cycle between edges 0 and 1.
- tx_done_tick sampled at edge k in WAIT:
  - Burst continues: next tx_start in cycle k..k+1.
  - Release: busy low after edge k; next grant no earlier than edge k+1.
- Minimum spacing between tx_start pulses: 2 cycles.
- The grant and tx_din registers are glitch-free. tx_start and req_ack are decodes of registered state.

## Test plan
- Single request, NREQ=4: req=0001 with data 0x55 → after edge 0, grant=0001, tx_din=0x55, one tx_start and req_ack=0001 pulse. tx_done_tick → grant=0000, busy=0.
- All requesting, MAX_BURST=1: req=1111 held, each byte completed by tx_done_tick → grant sequence 0001, 0010, 0100, 1000, 0001.
- Burst limit, MAX_BURST=4: req0 held high with bytes 0x01..0x06, req1 high:
  - Four bytes go out from req0 (0x01..0x04).
  - grant then moves to 0010.
  - req0 resumes with 0x05 after req1 is released.
- Requester drop: req2 drops right after req_ack → the current byte finishes; release on tx_done_tick; no second tx_start.
- Watchdog, TO_BITS=4: no tx_done_tick → after 15 WAIT cycles, one timeout_err pulse, grant=0, state IDLE. Also: done and expiry in the same cycle → no timeout_err.
- Reset mid-burst: reset_n low during WAIT → immediately grant=0, busy=0, tx_start=0. After release, req=0110 → requester 1 is granted first.
